// File: rtl/cdc_bus_tx.sv
// Transmit side of a toggle-handshake bus synchronizer: latches a word, flips req_o,
// and waits for the resynchronized ack toggle before accepting the next word.
module cdc_bus_tx #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic             proto_err_o,
  output logic             timeout_o
);

  // Keep at least one counter bit so the logic stays legal when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic                   perr_q, perr_d;
  logic                   to_q, to_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_s;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ack_i};
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Any ack movement while nothing is outstanding means the peer is out of phase.
        if (ack_s != req_q) perr_d = 1'b1;
        if (valid_i) begin
          data_d  = data_i;
          req_d   = ~req_q;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_s == req_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) to_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign done_o      = done_q;
  assign proto_err_o = perr_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Directed bench for cdc_bus_tx (WIDTH=4, SYNC_STAGES=3, TIMEOUT=8).
module tb_cdc_bus_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [3:0] data_i;
  logic       ready_o;
  logic       req_o;
  logic [3:0] data_o;
  logic       ack_i;
  logic       done_o;
  logic       proto_err_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  cdc_bus_tx #(.WIDTH(4), .SYNC_STAGES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .done_o(done_o), .proto_err_o(proto_err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic       ack;
    logic       e_ready;
    logic       e_req;
    logic [3:0] e_data;
    logic       e_done;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [3:0] d, logic a, logic r, logic q,
                              logic [3:0] ed, logic dn);
    vec_t t;
    t.valid = v; t.data = d; t.ack = a;
    t.e_ready = r; t.e_req = q; t.e_data = ed; t.e_done = dn;
    return t;
  endfunction

  initial begin
    int dones;
    int n;
    bit seen;

    vec[0]  = mk(1, 4'hA, 0, 0, 1, 4'hA, 0);
    for (int i = 1; i <= 4; i++) vec[i] = mk(0, 4'h0, 0, 0, 1, 4'hA, 0);
    for (int i = 5; i <= 7; i++) vec[i] = mk(0, 4'h0, 1, 0, 1, 4'hA, 0);
    vec[8]  = mk(1, 4'h5, 1, 1, 1, 4'hA, 1);
    vec[9]  = mk(1, 4'h5, 1, 0, 0, 4'h5, 0);
    for (int i = 10; i <= 12; i++) vec[i] = mk(0, 4'h0, 0, 0, 0, 4'h5, 0);
    vec[13] = mk(0, 4'h0, 0, 1, 0, 4'h5, 1);
    vec[14] = mk(0, 4'h0, 0, 1, 0, 4'h5, 0);

    rst_n = 1'b0; valid_i = 1'b0; data_i = 4'h0; ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_req", req_o, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", ready_o, 1);
      chk("idle_req", req_o, 0);
      chk("idle_data", data_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_perr", proto_err_o, 0);
      chk("idle_tout", timeout_o, 0);
    end

    // Single transfer, simultaneous done/valid, back-to-back accept.
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      valid_i = vec[i].valid;
      data_i  = vec[i].data;
      ack_i   = vec[i].ack;
      step();
      chk($sformatf("vec%0d_ready", i), ready_o, vec[i].e_ready);
      chk($sformatf("vec%0d_req", i), req_o, vec[i].e_req);
      chk($sformatf("vec%0d_data", i), data_o, vec[i].e_data);
      chk($sformatf("vec%0d_done", i), done_o, vec[i].e_done);
      chk($sformatf("vec%0d_perr", i), proto_err_o, 0);
      if (done_o) dones++;
    end
    chk("done_pulses", dones, 2);

    // Hold during WAIT while no ack arrives; timeout must assert and stick.
    valid_i = 1'b1; data_i = 4'h3;
    step();
    chk("hold_accept_req", req_o, 1);
    chk("hold_accept_data", data_o, 4'h3);
    for (int i = 0; i < 16; i++) begin
      data_i = 4'(i);
      valid_i = 1'b1;
      step();
      chk("hold_data", data_o, 4'h3);
      chk("hold_req", req_o, 1);
      chk("hold_ready", ready_o, 0);
      chk("hold_done", done_o, 0);
      if (i == 3) chk("tout_early", timeout_o, 0);
    end
    chk("tout_set", timeout_o, 1);

    valid_i = 1'b0; ack_i = 1'b1;
    n = 0; seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      step();
      if (done_o) begin seen = 1; n = i; end
    end
    chk("late_done_seen", seen, 1);
    chk("late_done_latency", n, 4);
    chk("tout_sticky", timeout_o, 1);
    chk("late_ready", ready_o, 1);

    // Protocol error: ack toggles while idle.
    ack_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("perr_pending", proto_err_o, 0);
    end
    step();
    chk("perr_set", proto_err_o, 1);
    chk("perr_ready", ready_o, 1);

    // Async reset in the middle of a WAIT.
    valid_i = 1'b1; data_i = 4'hF;
    step();
    chk("mid_accept_req", req_o, 0);
    chk("mid_accept_data", data_o, 4'hF);
    chk("mid_accept_ready", ready_o, 0);
    valid_i = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1);
    chk("arst_req", req_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_perr", proto_err_o, 0);
    chk("arst_tout", timeout_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
